// File: rtl/div_resource_controller_if.sv
// ---------------------------------------------------------------------------
// div_resource_controller_if
//   Bundles the handshake and status signals between the pipeline (scheduler,
//   issue, execution and flush sources) and the divider ownership controller.
//
//   Pipeline -> controller (all NUM_DIV wide unless noted):
//     stall (1 bit)   execution stall, blocks acceptance of req
//     acquire         issue stage reserves divider i
//     req             execution stage starts a division on divider i
//     releaseDiv      result consumed, divider i returns to the pool
//                     ("release" is a reserved word, hence the suffix)
//     resetFromIssue / resetFromRegRead / resetFromTagAccess
//                     flush of the owning instruction at that stage
//   Controller -> pipeline / datapath:
//     divStart, divAbort               1-cycle strobes to the divider datapath
//     free, reserved, busy, finished   one-hot lane status
//     protocolError                    sticky illegal-handshake flag per lane
// ---------------------------------------------------------------------------
interface div_resource_controller_if #(
  parameter int NUM_DIV = 2
);
  logic               stall;
  logic [NUM_DIV-1:0] acquire;
  logic [NUM_DIV-1:0] req;
  logic [NUM_DIV-1:0] releaseDiv;
  logic [NUM_DIV-1:0] resetFromIssue;
  logic [NUM_DIV-1:0] resetFromRegRead;
  logic [NUM_DIV-1:0] resetFromTagAccess;
  logic [NUM_DIV-1:0] divStart;
  logic [NUM_DIV-1:0] divAbort;
  logic [NUM_DIV-1:0] free;
  logic [NUM_DIV-1:0] reserved;
  logic [NUM_DIV-1:0] busy;
  logic [NUM_DIV-1:0] finished;
  logic [NUM_DIV-1:0] protocolError;

  // Pipeline side: drives requests, observes status.
  modport master (
    output stall, acquire, req, releaseDiv,
           resetFromIssue, resetFromRegRead, resetFromTagAccess,
    input  divStart, divAbort, free, reserved, busy, finished, protocolError
  );

  // Controller side.
  modport slave (
    input  stall, acquire, req, releaseDiv,
           resetFromIssue, resetFromRegRead, resetFromTagAccess,
    output divStart, divAbort, free, reserved, busy, finished, protocolError
  );
endinterface

// File: rtl/div_resource_controller.sv
// ---------------------------------------------------------------------------
// div_resource_controller
//   Per-lane ownership controller for the shared iterative integer dividers.
//   Each lane walks FREE -> RESERVED (acquire) -> BUSY (req, not stalled)
//   -> FINISHED (fixed latency elapsed) -> FREE (releaseDiv). Any flush of
//   the owner returns the lane to FREE and aborts a running division.
//
//   Ports:
//     clk   clock, all state updates on the rising edge
//     rst   synchronous active-high reset
//     bus   div_resource_controller_if.slave, see the interface for signals
//
//   Parameters:
//     NUM_DIV      number of independent divider lanes
//     DIV_LATENCY  cycles a division occupies BUSY (>= 1)
// ---------------------------------------------------------------------------
module div_resource_controller #(
  parameter int NUM_DIV     = 2,
  parameter int DIV_LATENCY = 34
) (
  input  logic                      clk,
  input  logic                      rst,
  div_resource_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_RESERVED = 2'd1,
    ST_BUSY     = 2'd2,
    ST_FINISHED = 2'd3
  } divState_e;

  logic [NUM_DIV-1:0] divStartS;
  logic [NUM_DIV-1:0] divAbortS;
  logic [NUM_DIV-1:0] freeS;
  logic [NUM_DIV-1:0] reservedS;
  logic [NUM_DIV-1:0] busyS;
  logic [NUM_DIV-1:0] finishedS;
  logic [NUM_DIV-1:0] protocolErrorS;

  genvar i;
  for (i = 0; i < NUM_DIV; i++) begin : gLane
    divState_e        stateR;
    divState_e        stateNxtS;
    logic [CNT_W-1:0] cntR;
    logic [CNT_W-1:0] cntNxtS;
    logic             errR;
    logic             errSetS;
    logic             startS;
    logic             abortS;
    logic             flushS;
    logic             acqS;
    logic             reqS;
    logic             relS;

    assign flushS = bus.resetFromIssue[i] | bus.resetFromRegRead[i] |
                    bus.resetFromTagAccess[i];
    assign acqS   = bus.acquire[i];
    assign reqS   = bus.req[i];
    assign relS   = bus.releaseDiv[i];

    // Next-state, counter and strobe logic; flush overrides every state.
    always_comb begin
      stateNxtS = stateR;
      cntNxtS   = cntR;
      errSetS   = 1'b0;
      startS    = 1'b0;
      abortS    = 1'b0;
      if (flushS) begin
        stateNxtS = ST_FREE;
        cntNxtS   = {CNT_W{1'b0}};
        // Only a division actually running in the datapath needs aborting.
        abortS    = (stateR == ST_BUSY);
      end else begin
        case (stateR)
          ST_FREE: begin
            if (acqS) begin
              stateNxtS = ST_RESERVED;
            end else begin
              stateNxtS = ST_FREE;
            end
            errSetS = reqS | relS;
          end
          ST_RESERVED: begin
            // A stalled req is not consumed; the requester keeps it held.
            if (reqS && !bus.stall) begin
              stateNxtS = ST_BUSY;
              cntNxtS   = CNT_W'(DIV_LATENCY - 1);
              startS    = 1'b1;
            end else begin
              stateNxtS = ST_RESERVED;
            end
            errSetS = acqS | relS;
          end
          ST_BUSY: begin
            // The divider keeps iterating through execution stalls.
            if (cntR == {CNT_W{1'b0}}) begin
              stateNxtS = ST_FINISHED;
            end else begin
              cntNxtS = cntR - CNT_W'(1);
            end
            errSetS = reqS | acqS | relS;
          end
          ST_FINISHED: begin
            if (relS) begin
              // Release plus acquire hands the lane straight to the next owner.
              if (acqS) begin
                stateNxtS = ST_RESERVED;
              end else begin
                stateNxtS = ST_FREE;
              end
              errSetS = reqS;
            end else begin
              stateNxtS = ST_FINISHED;
              errSetS   = reqS | acqS;
            end
          end
          default: begin
            stateNxtS = ST_FREE;
            cntNxtS   = {CNT_W{1'b0}};
            errSetS   = 1'b1;
          end
        endcase
      end
    end

    // Lane state, latency counter and sticky error register.
    always_ff @(posedge clk) begin
      if (rst) begin
        stateR <= ST_FREE;
        cntR   <= {CNT_W{1'b0}};
        errR   <= 1'b0;
      end else begin
        stateR <= stateNxtS;
        cntR   <= cntNxtS;
        errR   <= errR | errSetS;
      end
    end

    // Strobes are suppressed under rst: reset clears the datapath itself.
    assign divStartS[i]      = startS & ~rst;
    assign divAbortS[i]      = abortS & ~rst;
    assign freeS[i]          = (stateR == ST_FREE);
    assign reservedS[i]      = (stateR == ST_RESERVED);
    assign busyS[i]          = (stateR == ST_BUSY);
    assign finishedS[i]      = (stateR == ST_FINISHED);
    assign protocolErrorS[i] = errR;
  end

  assign bus.divStart      = divStartS;
  assign bus.divAbort      = divAbortS;
  assign bus.free          = freeS;
  assign bus.reserved      = reservedS;
  assign bus.busy          = busyS;
  assign bus.finished      = finishedS;
  assign bus.protocolError = protocolErrorS;

endmodule

// File: tb/tb_div_resource_controller.sv
// ---------------------------------------------------------------------------
// tb_div_resource_controller
//   Self-checking bench for div_resource_controller (NUM_DIV=2, DIV_LATENCY=4).
//   Directed scenarios check cycle-exact behaviour against hand-derived
//   timelines; a randomized phase compares every output against a
//   timestamp-based ownership model.
// ---------------------------------------------------------------------------
module tb_div_resource_controller;
  localparam int N = 2;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_resource_controller_if #(.NUM_DIV(N)) bus ();

  div_resource_controller #(.NUM_DIV(N), .DIV_LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a lane is either unowned, owned-but-not-started, or
  // started at a known cycle; busy/finished follow from elapsed time.
  logic [N-1:0] ownedM;
  logic [N-1:0] startedM;
  logic [N-1:0] errM;
  int           startCyc [N];
  int           cyc = 0;

  function automatic logic flushM(int i);
    return bus.resetFromIssue[i] | bus.resetFromRegRead[i] | bus.resetFromTagAccess[i];
  endfunction
  function automatic logic mRes(int i);
    return ownedM[i] && !startedM[i];
  endfunction
  function automatic logic mBusy(int i);
    return ownedM[i] && startedM[i] && (cyc <= startCyc[i] + L);
  endfunction
  function automatic logic mFin(int i);
    return ownedM[i] && startedM[i] && (cyc > startCyc[i] + L);
  endfunction

  // Expected {divStart, divAbort, free, reserved, busy, finished, protocolError}.
  function automatic logic [7*N-1:0] expAll();
    logic [N-1:0] s, a, f, r, b, fi, e;
    for (int i = 0; i < N; i++) begin
      s[i]  = !rst && mRes(i) && bus.req[i] && !bus.stall && !flushM(i);
      a[i]  = !rst && mBusy(i) && flushM(i);
      f[i]  = !ownedM[i];
      r[i]  = mRes(i);
      b[i]  = mBusy(i);
      fi[i] = mFin(i);
      e[i]  = errM[i];
    end
    return {s, a, f, r, b, fi, e};
  endfunction

  // Model update on each rising edge from the inputs held during that cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      ownedM   <= '0;
      startedM <= '0;
      errM     <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (flushM(i)) begin
          ownedM[i]   <= 1'b0;
          startedM[i] <= 1'b0;
        end else if (!ownedM[i]) begin
          if (bus.acquire[i]) ownedM[i] <= 1'b1;
          if (bus.req[i] || bus.releaseDiv[i]) errM[i] <= 1'b1;
        end else if (mRes(i)) begin
          if (bus.req[i] && !bus.stall) begin
            startedM[i] <= 1'b1;
            startCyc[i] <= cyc;
          end
          if (bus.acquire[i] || bus.releaseDiv[i]) errM[i] <= 1'b1;
        end else if (mBusy(i)) begin
          if (bus.req[i] || bus.acquire[i] || bus.releaseDiv[i]) errM[i] <= 1'b1;
        end else begin
          if (bus.releaseDiv[i]) begin
            ownedM[i]   <= bus.acquire[i];
            startedM[i] <= 1'b0;
            if (bus.req[i]) errM[i] <= 1'b1;
          end else if (bus.acquire[i] || bus.req[i]) begin
            errM[i] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic clearIn();
    bus.stall              = 1'b0;
    bus.acquire            = '0;
    bus.req                = '0;
    bus.releaseDiv         = '0;
    bus.resetFromIssue     = '0;
    bus.resetFromRegRead   = '0;
    bus.resetFromTagAccess = '0;
  endtask

  task automatic test_reset();
    logic [7*N-1:0] obs;
    rst = 1'b1;
    clearIn();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    obs = {bus.divStart, bus.divAbort, bus.free, bus.reserved, bus.busy, bus.finished, bus.protocolError};
    vectors++;
    if (obs !== {2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected %b", obs,
               {2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
    end
  endtask

  // Acquire c0, req c2, release c8 on lane 0.
  task automatic test_latency();
    logic [4:0] obs, exp;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      clearIn();
      bus.acquire[0]    = (c == 0);
      bus.req[0]        = (c == 2);
      bus.releaseDiv[0] = (c == 8);
      #1;
      obs = {bus.free[0], bus.reserved[0], bus.busy[0], bus.finished[0], bus.divStart[0]};
      exp = {(c == 0 || c >= 9), (c >= 1 && c <= 2), (c >= 3 && c <= 6), (c >= 7 && c <= 8), (c == 2)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL latency c%0d: got fr/rs/bz/fn/st=%b expected %b", c, obs, exp);
      end
    end
  endtask

  // Req held c2..c5 with stall c2..c4: start only at c5, finished from c10.
  task automatic test_stall();
    logic [5:0] obs, exp;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      clearIn();
      bus.acquire[0]    = (c == 0);
      bus.req[0]        = (c >= 2 && c <= 5);
      bus.stall         = (c >= 2 && c <= 4);
      bus.releaseDiv[0] = (c == 11);
      #1;
      obs = {bus.free[0], bus.reserved[0], bus.busy[0], bus.finished[0], bus.divStart[0], bus.protocolError[0]};
      exp = {(c == 0 || c == 12), (c >= 1 && c <= 5), (c >= 6 && c <= 9), (c >= 10 && c <= 11), (c == 5), 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL stall c%0d: got fr/rs/bz/fn/st/er=%b expected %b", c, obs, exp);
      end
    end
  endtask

  // Lane 1 started c1, flushed from register-read at c3 while cnt==2.
  task automatic test_flush();
    logic [4:0] obs, exp;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      clearIn();
      bus.acquire[1]          = (c == 0);
      bus.req[1]              = (c == 1);
      bus.resetFromRegRead[1] = (c == 3);
      #1;
      obs = {bus.free[1], bus.busy[1], bus.finished[1], bus.divStart[1], bus.divAbort[1]};
      exp = {(c == 0 || c >= 4), (c >= 2 && c <= 3), 1'b0, (c == 1), (c == 3)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL flush c%0d: got fr/bz/fn/st/ab=%b expected %b", c, obs, exp);
      end
    end
  endtask

  // Finished at c6, release+acquire at c6, issue flush at c8 to clean up.
  task automatic test_back_to_back();
    logic [4:0] obs, exp;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      clearIn();
      bus.acquire[0]        = (c == 0 || c == 6);
      bus.req[0]            = (c == 1);
      bus.releaseDiv[0]     = (c == 6);
      bus.resetFromIssue[0] = (c == 8);
      #1;
      obs = {bus.free[0], bus.reserved[0], bus.finished[0], bus.divAbort[0], bus.protocolError[0]};
      exp = {(c == 0 || c == 9), (c == 1 || c == 7 || c == 8), (c == 6), 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL back_to_back c%0d: got fr/rs/fn/ab/er=%b expected %b", c, obs, exp);
      end
    end
  endtask

  // req[1] while FREE at c0; acquire[0] while BUSY at c3.
  task automatic test_protocol_error();
    logic [6:0] obs, exp;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      clearIn();
      bus.req[1]        = (c == 0);
      bus.acquire[0]    = (c == 0 || c == 3);
      bus.req[0]        = (c == 1);
      bus.releaseDiv[0] = (c == 7);
      #1;
      obs = {bus.protocolError, bus.free[1], bus.free[0], bus.busy[0], bus.finished[0]};
      exp = {(c >= 1), (c >= 4), 1'b1, (c == 0 || c >= 8), (c >= 2 && c <= 5), (c >= 6 && c <= 7)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL protocol_error c%0d: got er1/er0/fr1/fr0/bz0/fn0=%b expected %b", c, obs, exp);
      end
    end
    // A flush must not clear the sticky flags.
    @(negedge clk);
    clearIn();
    bus.resetFromTagAccess = 2'b11;
    @(negedge clk);
    clearIn();
    #1;
    vectors++;
    if (bus.protocolError !== 2'b11) begin
      miscompares++;
      $display("FAIL error_sticky: got %b expected %b", bus.protocolError, 2'b11);
    end
  endtask

  // Both lanes busy, rst pulsed at c3.
  task automatic test_reset_mid_busy();
    logic [7*N-1:0] obs;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clearIn();
      bus.acquire = (c == 0) ? 2'b11 : 2'b00;
      bus.req     = (c == 1) ? 2'b11 : 2'b00;
      rst         = (c == 3);
      #1;
      if (c == 2) begin
        vectors++;
        if (bus.busy !== 2'b11) begin
          miscompares++;
          $display("FAIL reset_mid_busy_pre: got busy %b expected %b", bus.busy, 2'b11);
        end
      end
      if (c == 4) begin
        obs = {bus.divStart, bus.divAbort, bus.free, bus.reserved, bus.busy, bus.finished, bus.protocolError};
        vectors++;
        if (obs !== {2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00}) begin
          miscompares++;
          $display("FAIL reset_mid_busy: got %b expected %b", obs,
                   {2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00});
        end
      end
    end
  endtask

  // Random per-lane actions with occasional rst, checked against the model.
  task automatic test_random();
    logic [7*N-1:0] obs, exp;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      clearIn();
      rst       = ($urandom_range(0, 79) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 11))
          3, 9:    bus.acquire[i] = 1'b1;
          4, 8, 10: bus.req[i] = 1'b1;
          5:       bus.releaseDiv[i] = 1'b1;
          6, 11: begin
            bus.releaseDiv[i] = 1'b1;
            bus.acquire[i]    = 1'b1;
          end
          7: begin
            case ($urandom_range(0, 2))
              0:       bus.resetFromIssue[i] = 1'b1;
              1:       bus.resetFromRegRead[i] = 1'b1;
              default: bus.resetFromTagAccess[i] = 1'b1;
            endcase
          end
          default: ;
        endcase
      end
      #1;
      obs = {bus.divStart, bus.divAbort, bus.free, bus.reserved, bus.busy, bus.finished, bus.protocolError};
      exp = expAll();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL random c%0d: got st/ab/fr/rs/bz/fn/er=%b expected %b", c, obs, exp);
      end
    end
    @(negedge clk);
    clearIn();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clearIn();
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_back_to_back();
    test_protocol_error();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
